// File: rtl/dmx_pkg.sv
// Shared DMX512 definitions: slot limits, line-state enum and
// timing helpers used by both the input and output paths.
package dmx_pkg;

  localparam int DMX_MAX_SLOTS = 513;
  localparam int DMX_ADDR_W    = 10;
  localparam int DMX_STOP_BITS = 2;
  localparam int DMX_TMR_W     = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BREAK,
    ST_MAB,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_MBB
  } dmx_state_e;

  function automatic int us_to_cyc(int clk_hz, int us);
    return int'((longint'(clk_hz) * longint'(us)) / 64'd1_000_000);
  endfunction

  function automatic int baud_to_cyc(int clk_hz, int baud);
    return clk_hz / baud;
  endfunction

  // 0 still sends a start code; anything above the buffer is capped.
  function automatic logic [DMX_ADDR_W-1:0] dmx_clamp_slots(
    logic [DMX_ADDR_W-1:0] n,
    logic [DMX_ADDR_W-1:0] mx
  );
    if (n == '0) return DMX_ADDR_W'(1);
    if (n > mx) return mx;
    return n;
  endfunction

endpackage

// File: rtl/dmx_byte_serializer.sv
// One DMX slot on the wire: start bit, 8 data bits LSB first,
// two stop bits, each bit_cyc clocks long.
module dmx_byte_serializer
  import dmx_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [7:0]           byte_in,
  input  logic [DMX_TMR_W-1:0] bit_cyc,
  output logic                 tx_bit,
  output logic                 byte_done,
  output logic                 fetch
);

  dmx_state_e           ph_q, ph_d;
  logic [DMX_TMR_W-1:0] cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [7:0]           sh_q, sh_d;
  logic                 last;

  assign last = (cnt_q == '0);

  always_comb begin
    ph_d      = ph_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    byte_done = 1'b0;
    fetch     = 1'b0;
    case (ph_q)
      ST_START: begin
        cnt_d = last ? bit_cyc - 1'b1 : cnt_q - 1'b1;
        if (last) begin
          ph_d  = ST_DATA;
          bit_d = '0;
        end
      end
      ST_DATA: begin
        cnt_d = last ? bit_cyc - 1'b1 : cnt_q - 1'b1;
        if (last) begin
          sh_d = sh_q >> 1;
          if (bit_q == 4'd7) begin
            ph_d  = ST_STOP;
            bit_d = '0;
            fetch = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_STOP: begin
        cnt_d = last ? bit_cyc - 1'b1 : cnt_q - 1'b1;
        if (last) begin
          if (bit_q == 4'(DMX_STOP_BITS - 1)) begin
            byte_done = 1'b1;
            ph_d      = ST_IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
    // Back-to-back slots: a load on the final stop cycle wins.
    if (load) begin
      ph_d  = ST_START;
      cnt_d = bit_cyc - 1'b1;
      bit_d = '0;
      sh_d  = byte_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ph_q  <= ST_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q  <= '0;
    end else begin
      ph_q  <= ph_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q  <= sh_d;
    end
  end

  always_comb begin
    tx_bit = 1'b1;
    if (ph_q == ST_START) tx_bit = 1'b0;
    else if (ph_q == ST_DATA) tx_bit = sh_q[0];
  end

endmodule

// File: rtl/dmx_output_frame_tx.sv
// DMX512 frame transmitter: break, MAB, slots fetched from EBR,
// MBB, repeating while enabled.
module dmx_output_frame_tx
  import dmx_pkg::*;
#(
  parameter int CLK_FREQ        = 20_000_000,
  parameter int BAUD_RATE       = 250_000,
  parameter int BREAK_US        = 176,
  parameter int MAB_US          = 12,
  parameter int MBB_US          = 20,
  parameter int DMX_BUFFER_SIZE = DMX_MAX_SLOTS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [9:0] slot_count,
  output logic [9:0] mem_addr,
  input  logic [7:0] mem_data,
  output logic       tx,
  output logic       DE,
  output logic       frame_busy,
  output logic       frame_done,
  output logic       Signal_Sending_LED
);

  localparam logic [DMX_TMR_W-1:0] BIT_CYC =
    DMX_TMR_W'(baud_to_cyc(CLK_FREQ, BAUD_RATE));
  localparam logic [DMX_TMR_W-1:0] BREAK_CYC =
    DMX_TMR_W'(us_to_cyc(CLK_FREQ, BREAK_US));
  localparam logic [DMX_TMR_W-1:0] MAB_CYC =
    DMX_TMR_W'(us_to_cyc(CLK_FREQ, MAB_US));
  localparam logic [DMX_TMR_W-1:0] MBB_CYC =
    DMX_TMR_W'(us_to_cyc(CLK_FREQ, MBB_US));
  localparam logic [DMX_ADDR_W-1:0] MAX_CNT =
    DMX_ADDR_W'(DMX_BUFFER_SIZE);

  dmx_state_e            state_q, state_d;
  logic [DMX_TMR_W-1:0]  tmr_q, tmr_d;
  logic [DMX_ADDR_W-1:0] slot_q, slot_d;
  logic [DMX_ADDR_W-1:0] eff_q, eff_d;
  logic [DMX_ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]            hold_q, hold_d;
  logic                  pend_q, pend_d;
  logic                  cap_q, cap_d;
  logic                  done_q, done_d;
  logic                  ser_load, ser_tx, ser_done, ser_fetch;
  logic                  more;

  dmx_byte_serializer u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (ser_load),
    .byte_in  (hold_q),
    .bit_cyc  (BIT_CYC),
    .tx_bit   (ser_tx),
    .byte_done(ser_done),
    .fetch    (ser_fetch)
  );

  assign more = (slot_q + 1'b1) < eff_q;

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    slot_d   = slot_q;
    eff_d    = eff_q;
    addr_d   = addr_q;
    hold_d   = hold_q;
    pend_d   = 1'b0;
    cap_d    = pend_q;
    done_d   = 1'b0;
    ser_load = 1'b0;
    // EBR read data lands one clock after the address.
    if (cap_q) hold_d = mem_data;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_BREAK;
          tmr_d   = BREAK_CYC - 1'b1;
          eff_d   = dmx_clamp_slots(slot_count, MAX_CNT);
        end
      end
      ST_BREAK: begin
        tmr_d = tmr_q - 1'b1;
        if (tmr_q == '0) begin
          state_d = ST_MAB;
          tmr_d   = MAB_CYC - 1'b1;
          addr_d  = '0;
          pend_d  = 1'b1;
        end
      end
      ST_MAB: begin
        tmr_d = tmr_q - 1'b1;
        if (tmr_q == '0) begin
          state_d  = ST_START;
          slot_d   = '0;
          ser_load = 1'b1;
        end
      end
      ST_START: begin
        if (ser_fetch && more) begin
          addr_d = slot_q + 1'b1;
          pend_d = 1'b1;
        end
        if (ser_done) begin
          if (more) begin
            ser_load = 1'b1;
            slot_d   = slot_q + 1'b1;
          end else begin
            state_d = ST_MBB;
            tmr_d   = MBB_CYC - 1'b1;
            done_d  = 1'b1;
          end
        end
      end
      ST_MBB: begin
        tmr_d = tmr_q - 1'b1;
        if (tmr_q == '0) begin
          if (enable) begin
            state_d = ST_BREAK;
            tmr_d   = BREAK_CYC - 1'b1;
            eff_d   = dmx_clamp_slots(slot_count, MAX_CNT);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      slot_q  <= '0;
      eff_q   <= DMX_ADDR_W'(1);
      addr_q  <= '0;
      hold_q  <= '0;
      pend_q  <= 1'b0;
      cap_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      slot_q  <= slot_d;
      eff_q   <= eff_d;
      addr_q  <= addr_d;
      hold_q  <= hold_d;
      pend_q  <= pend_d;
      cap_q   <= cap_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    tx = 1'b1;
    if (state_q == ST_BREAK) tx = 1'b0;
    else if (state_q == ST_START) tx = ser_tx;
  end

  assign DE                 = (state_q != ST_IDLE);
  assign frame_busy         = DE;
  assign Signal_Sending_LED = DE;
  assign frame_done         = done_q;
  assign mem_addr           = addr_q;

endmodule
